// File: rtl/pe_drn_pkg.sv
// Shared sizing, FSM state type and the requantization rule for the PE psum drain.
package pe_drn_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int BLOCK_DEPTH = 32;
  localparam int ACC_W       = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int MAC_W       = 2 * DATA_WIDTH + $clog2(3 * BLOCK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} drn_state_e;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Round-half-up shift, optional ReLU, then clamp; one extra bit keeps the rounding add exact.
  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [ACC_W-1:0] acc,
    input logic        [4:0]       shift,
    input logic                    relu
  );
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    rnd = '0;
    if (shift != 5'd0) rnd = (ACC_W+1)'(1) << (shift - 5'd1);
    sum = {acc[ACC_W-1], acc} + rnd;
    sum = sum >>> shift;
    if (relu && sum < 0) sum = '0;
    if (sum > (ACC_W+1)'(SAT_MAX)) sum = (ACC_W+1)'(SAT_MAX);
    if (sum < (ACC_W+1)'(SAT_MIN)) sum = (ACC_W+1)'(SAT_MIN);
    return sum[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pe_psum_drain_if.sv
// Output stream from the drain toward the global buffer (valid/ready).
interface pe_psum_drain_if;
  import pe_drn_pkg::*;

  logic [DATA_WIDTH-1:0] DRNGB_Dat;
  logic                  DRNGB_Val;
  logic                  GBDRN_Rdy;

  modport master (output DRNGB_Dat, output DRNGB_Val, input  GBDRN_Rdy);
  modport slave  (input  DRNGB_Dat, input  DRNGB_Val, output GBDRN_Rdy);

endinterface

// File: rtl/pe_drn_fifo.sv
// Small first-word-fall-through FIFO; dout always shows the head entry.
module pe_drn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue only lands when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pe_psum_drain.sv
// Accumulates MAC block results into psums, requantizes them and queues them toward the global buffer.
module pe_psum_drain
  import pe_drn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Cfg_Sta,
  input  logic [7:0]              Cfg_NumBlk,
  input  logic [15:0]             Cfg_NumOut,
  input  logic [4:0]              Cfg_Shift,
  input  logic                    Cfg_Relu,
  input  logic signed [ACC_W-1:0] Cfg_Bias,
  input  logic                    MACPEC_Fnh,
  input  logic signed [MAC_W-1:0] MACCNV_Mac,
  output logic                    DRN_Rdy,
  output logic                    DRN_Done,
  output logic                    DRN_Ovf,
  pe_psum_drain_if.master         gb
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  drn_state_e                   state;
  logic                         fnh_d;
  logic [7:0]                   num_blk;
  logic [7:0]                   blk_cnt;
  logic [15:0]                  num_out;
  logic [15:0]                  out_cnt;
  logic [4:0]                   shift;
  logic                         relu;
  logic signed [ACC_W-1:0]      bias;
  logic signed [ACC_W-1:0]      acc;
  logic                         v1;
  logic                         v2;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         pop;
  logic                         ev;
  logic                         last_blk;
  logic [CNT_W:0]               occ;
  logic signed [ACC_W-1:0]      mac_ext;

  assign ev        = MACPEC_Fnh & ~fnh_d & (state == RUN) & (out_cnt < num_out);
  assign last_blk  = (blk_cnt == num_blk - 8'd1);
  assign mac_ext   = ACC_W'(MACCNV_Mac);
  assign pop       = gb.DRNGB_Val & gb.GBDRN_Rdy;
  assign gb.DRNGB_Val = ~fifo_empty;
  assign DRN_Done  = (state == DONE);

  // Words already committed to the queue or still in the pipe, plus the one about to be issued.
  assign occ = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(v1) + (CNT_W+1)'(v2) + (CNT_W+1)'(1);

  pe_drn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2),
    .din   (r_q),
    .pop   (pop),
    .dout  (gb.DRNGB_Dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Run control, accumulation and the two-stage requant pipe share one register block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fnh_d   <= 1'b1;
      num_blk <= 8'd1;
      num_out <= '0;
      shift   <= '0;
      relu    <= 1'b0;
      bias    <= '0;
      blk_cnt <= '0;
      out_cnt <= '0;
      acc     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      r_q     <= '0;
      DRN_Rdy <= 1'b0;
      DRN_Ovf <= 1'b0;
    end else begin
      fnh_d   <= MACPEC_Fnh;
      v1      <= 1'b0;
      v2      <= v1;
      r_q     <= requant(acc, shift, relu);
      DRN_Rdy <= (state == RUN) && (out_cnt < num_out) && (occ <= (CNT_W+1)'(FIFO_DEPTH));
      if (v2 && fifo_full && !pop) DRN_Ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (Cfg_Sta) begin
            num_blk <= (Cfg_NumBlk == 8'd0) ? 8'd1 : Cfg_NumBlk;
            num_out <= Cfg_NumOut;
            shift   <= Cfg_Shift;
            relu    <= Cfg_Relu;
            bias    <= Cfg_Bias;
            blk_cnt <= '0;
            out_cnt <= '0;
            DRN_Ovf <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (ev) begin
            acc <= (blk_cnt == 8'd0) ? mac_ext + bias : acc + mac_ext;
            if (last_blk) begin
              blk_cnt <= '0;
              out_cnt <= out_cnt + 16'd1;
              v1      <= 1'b1;
            end else begin
              blk_cnt <= blk_cnt + 8'd1;
            end
          end
          if (out_cnt == num_out && !v1 && !v2 && fifo_empty) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
